// File: rtl/s_axil_reg_bank.sv
// AXI4-Lite slave register bank: RW control / RO status registers, self-clearing
// pulse registers, byte strobes, SLVERR for RO/out-of-range, per-register access strobes.
module s_axil_reg_bank #(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             N_REGS     = 8,
    parameter int                             ADDR_WIDTH = 8,
    parameter logic [N_REGS-1:0]              RO_MASK    = '0,
    parameter logic [N_REGS-1:0]              PULSE_MASK = '0,
    parameter logic [N_REGS*DATA_WIDTH-1:0]   RST_VAL    = '0
) (
    input  logic                              axi_clock,
    input  logic                              rst,

    input  logic [ADDR_WIDTH-1:0]             s_axil_awaddr,
    input  logic [2:0]                        s_axil_awprot,
    input  logic                              s_axil_awvalid,
    output logic                              s_axil_awready,
    input  logic [DATA_WIDTH-1:0]             s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]           s_axil_wstrb,
    input  logic                              s_axil_wvalid,
    output logic                              s_axil_wready,
    output logic [1:0]                        s_axil_bresp,
    output logic                              s_axil_bvalid,
    input  logic                              s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]             s_axil_araddr,
    input  logic [2:0]                        s_axil_arprot,
    input  logic                              s_axil_arvalid,
    output logic                              s_axil_arready,
    output logic [DATA_WIDTH-1:0]             s_axil_rdata,
    output logic [1:0]                        s_axil_rresp,
    output logic                              s_axil_rvalid,
    input  logic                              s_axil_rready,

    output logic [N_REGS*DATA_WIDTH-1:0]      ctrl_regs,
    input  logic [N_REGS*DATA_WIDTH-1:0]      status_regs,
    output logic [N_REGS-1:0]                 wr_pulse,
    output logic [N_REGS-1:0]                 rd_pulse
);

    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam int         N_BYTES     = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32) begin : g_chk_data_width
        $error("s_axil_reg_bank: DATA_WIDTH must be 32");
    end
    if (N_REGS < 1 || N_REGS > 64) begin : g_chk_n_regs
        $error("s_axil_reg_bank: N_REGS must be in 1..64");
    end
    if (ADDR_WIDTH < $clog2(N_REGS) + 2) begin : g_chk_addr_width
        $error("s_axil_reg_bank: ADDR_WIDTH too small for N_REGS");
    end

    logic                  aw_valid_q;
    logic                  w_valid_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [N_BYTES-1:0]    w_strb_q;
    logic [DATA_WIDTH-1:0] ctrl_q [N_REGS];

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [IDX_W-1:0]      ar_idx;
    logic [N_REGS-1:0]     wr_sel;
    logic [N_REGS-1:0]     rd_sel;
    logic                  wr_ok;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;

    // Protection bits and the byte offset carry no meaning for word registers.
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0],
                             s_axil_araddr[1:0], status_regs};

    assign s_axil_awready = !rst && !aw_valid_q && !s_axil_bvalid;
    assign s_axil_wready  = !rst && !w_valid_q  && !s_axil_bvalid;
    assign s_axil_arready = !rst && !s_axil_rvalid;

    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid  && s_axil_wready;
    assign ar_hs  = s_axil_arvalid && s_axil_arready;
    assign commit = aw_valid_q && w_valid_q;
    assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        wr_sel  = '0;
        rd_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            wr_sel[i] = (aw_idx_q == IDX_W'(i)) && !RO_MASK[i];
            rd_sel[i] = (ar_idx == IDX_W'(i));
            if (rd_sel[i]) begin
                rd_word = RO_MASK[i] ? status_regs[i*DATA_WIDTH +: DATA_WIDTH] : ctrl_q[i];
            end
        end
    end

    assign wr_ok  = |wr_sel;
    assign rd_hit = |rd_sel;

    // Write channel: AW and W latch independently; the write commits once both are held.
    always_ff @(posedge axi_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            wr_pulse      <= '0;
        end else begin
            wr_pulse <= commit ? wr_sel : '0;
            if (aw_hs) begin
                aw_valid_q <= 1'b1;
                aw_idx_q   <= s_axil_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_valid_q <= 1'b1;
                w_data_q  <= s_axil_wdata;
                w_strb_q  <= s_axil_wstrb;
            end
            if (commit) begin
                aw_valid_q    <= 1'b0;
                w_valid_q     <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge axi_clock) begin
        if (rst) begin
            // NOTE: the register array is reset on purpose; software depends on the RST_VAL defaults.
            for (int i = 0; i < N_REGS; i++) begin
                ctrl_q[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                // Pulse registers fall back to zero unless a write lands this cycle.
                if (PULSE_MASK[i]) begin
                    ctrl_q[i] <= '0;
                end
                if (commit && wr_sel[i]) begin
                    for (int b = 0; b < N_BYTES; b++) begin
                        if (w_strb_q[b]) begin
                            ctrl_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: one-cycle latency, data held until rready.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
            rd_pulse      <= '0;
        end else begin
            rd_pulse <= ar_hs ? rd_sel : '0;
            if (ar_hs) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_word;
                s_axil_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_ctrl_out
        assign ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : ctrl_q[i];
    end

endmodule
